tl_phase_scheduler: RTL and testbench

//  Phase scheduler for the highway/farm-road intersection. Sequences the light phases and

---
 rtl/tl_pkg.sv | 47 ++++
 rtl/tl_req_latch.sv | 42 ++++
 rtl/tl_phase_scheduler.sv | 171 +++++++++++++++++
 tb/tb_tl_phase_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: state encoding, default durations and lamp encoding for the phase scheduler.
// Build option: TL_EMERGENCY_EN adds the ALL_RED state.
`default_nettype none

package tl_pkg;

   localparam int                DEF_CNT_W   = 12;
   localparam logic [DEF_CNT_W-1:0] DEF_T_LONG  = 12'h00A;
   localparam logic [DEF_CNT_W-1:0] DEF_T_SHORT = 12'h005;
   localparam logic [DEF_CNT_W-1:0] DEF_T_PED   = 12'h008;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HWY_G    = 3'd1,
      ST_HWY_Y    = 3'd2,
      ST_FARM_G   = 3'd3,
      ST_FARM_Y   = 3'd4,
      ST_PED_WALK = 3'd5
`ifdef TL_EMERGENCY_EN
      , ST_ALL_RED = 3'd6
`endif
   } state_t;

   // Lamp vector bit order: {HG, HY, HR, FG, FY, FR}
   typedef logic [5:0] lamps_t;

   localparam lamps_t LAMPS_HG_FR = 6'b100_001;
   localparam lamps_t LAMPS_HY_FR = 6'b010_001;
   localparam lamps_t LAMPS_HR_FG = 6'b001_100;
   localparam lamps_t LAMPS_HR_FY = 6'b001_010;
   localparam lamps_t LAMPS_HR_FR = 6'b001_001;

   function automatic lamps_t lamps_of(input state_t s);
      lamps_t l;
      case (s)
         ST_HWY_G:  l = LAMPS_HG_FR;
         ST_HWY_Y:  l = LAMPS_HY_FR;
         ST_FARM_G: l = LAMPS_HR_FG;
         ST_FARM_Y: l = LAMPS_HR_FY;
         default:   l = LAMPS_HR_FR;
      endcase
      return l;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tl_req_latch.sv
// tl_req_latch: sticky farm/pedestrian request flops with set-wins clear and a
// round-robin pointer that decides which requester the next highway yield serves.
`default_nettype none

module tl_req_latch (
   input  logic clk,
   input  logic reset,
   input  logic i_set_farm,
   input  logic i_set_ped,
   input  logic i_clr_farm,
   input  logic i_clr_ped,
   input  logic i_grant,
   output logic o_farm_pend,
   output logic o_ped_pend,
   output logic o_grant_farm
);

   logic r_farm;
   logic r_ped;
   logic r_rr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_farm <= 1'b0;
         r_ped  <= 1'b0;
         r_rr   <= 1'b0;
      end else begin
         r_farm <= i_set_farm | (r_farm & ~i_clr_farm);
         r_ped  <= i_set_ped  | (r_ped  & ~i_clr_ped);
         if (i_grant)
            r_rr <= ~r_rr;
      end
   end

   assign o_farm_pend  = r_farm;
   assign o_ped_pend   = r_ped;
   // rr==0 favours the farm road when both sides are waiting
   assign o_grant_farm = r_farm & (~r_ped | ~r_rr);

endmodule

`default_nettype wire

// File: rtl/tl_phase_scheduler.sv
// tl_phase_scheduler: highway/farm/pedestrian phase sequencer driving a shared expiry timer.
// Build option: TL_EMERGENCY_EN adds emg_req and the ALL_RED hold state.
`default_nettype none

module tl_phase_scheduler
   import tl_pkg::*;
#(
   parameter int               CNT_W   = DEF_CNT_W,
   parameter logic [CNT_W-1:0] T_LONG  = DEF_T_LONG,
   parameter logic [CNT_W-1:0] T_SHORT = DEF_T_SHORT,
   parameter logic [CNT_W-1:0] T_PED   = DEF_T_PED
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             c,
   input  logic             ped_req,
   input  logic             full,
   output logic             timer_load,
   output logic [CNT_W-1:0] timer_value,
   output logic             HG,
   output logic             HY,
   output logic             HR,
   output logic             FG,
   output logic             FY,
   output logic             FR,
   output logic             ped_walk,
   output logic             ped_ack
`ifdef TL_EMERGENCY_EN
   , input logic            emg_req
`endif
);

   state_t           r_state;
   state_t           w_next;
   logic             r_min_done;
   logic             r_load;
   logic [CNT_W-1:0] r_value;
   lamps_t           r_lamps;
   logic             r_walk;
   logic             r_ack;
   logic             w_full;
   logic             w_enter;
   logic             w_timed;
   logic [CNT_W-1:0] w_dur;
   logic             w_farm_pend;
   logic             w_ped_pend;
   logic             w_grant_farm;
   logic             w_grant;

   // An expiry coinciding with a fresh load belongs to the previous count
   assign w_full  = full & ~r_load;
   assign w_enter = (w_next != r_state);
   assign w_grant = (r_state == ST_HWY_Y) &&
                    ((w_next == ST_FARM_G) || (w_next == ST_PED_WALK));

`ifdef TL_EMERGENCY_EN
   logic r_emg;
   logic w_emg;
   assign w_emg = r_emg | emg_req;

   always_ff @(posedge clk) begin
      if (reset)
         r_emg <= 1'b0;
      else
         r_emg <= w_emg && (w_next != ST_ALL_RED) &&
                  (r_state inside {ST_HWY_G, ST_HWY_Y, ST_FARM_G, ST_FARM_Y});
   end
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:
            if (start) w_next = ST_HWY_G;
         ST_HWY_G: begin
            if ((w_full || r_min_done) && (w_farm_pend || w_ped_pend))
               w_next = ST_HWY_Y;
`ifdef TL_EMERGENCY_EN
            if (emg_req) w_next = ST_HWY_Y;
`endif
         end
         ST_HWY_Y:
            if (w_full) begin
               w_next = w_grant_farm ? ST_FARM_G : ST_PED_WALK;
`ifdef TL_EMERGENCY_EN
               if (w_emg) w_next = ST_ALL_RED;
`endif
            end
         ST_FARM_G: begin
            if (w_full) w_next = ST_FARM_Y;
`ifdef TL_EMERGENCY_EN
            if (emg_req) w_next = ST_FARM_Y;
`endif
         end
         ST_FARM_Y:
            if (w_full) begin
               w_next = ST_HWY_G;
`ifdef TL_EMERGENCY_EN
               if (w_emg) w_next = ST_ALL_RED;
`endif
            end
         ST_PED_WALK: begin
            if (w_full) w_next = ST_HWY_G;
`ifdef TL_EMERGENCY_EN
            if (emg_req) w_next = ST_ALL_RED;
`endif
         end
`ifdef TL_EMERGENCY_EN
         ST_ALL_RED:
            if (!emg_req) w_next = ST_HWY_G;
`endif
         default:
            w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_timed = 1'b1;
      w_dur   = '0;
      case (w_next)
         ST_HWY_G, ST_FARM_G: w_dur = T_LONG;
         ST_HWY_Y, ST_FARM_Y: w_dur = T_SHORT;
         ST_PED_WALK:         w_dur = T_PED;
         default:             w_timed = 1'b0;
      endcase
   end

   tl_req_latch u_req (
      .clk          (clk),
      .reset        (reset),
      .i_set_farm   (c),
      .i_set_ped    (ped_req),
      .i_clr_farm   (w_enter && (w_next == ST_FARM_G)),
      .i_clr_ped    (w_enter && (w_next == ST_PED_WALK)),
      .i_grant      (w_grant),
      .o_farm_pend  (w_farm_pend),
      .o_ped_pend   (w_ped_pend),
      .o_grant_farm (w_grant_farm)
   );

   // Outputs are registered from the next state so they change on the same edge as r_state
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_min_done <= 1'b0;
         r_load     <= 1'b0;
         r_value    <= '0;
         r_lamps    <= LAMPS_HR_FR;
         r_walk     <= 1'b0;
         r_ack      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_min_done <= (r_state == ST_HWY_G) && !w_enter && (r_min_done || w_full);
         r_load     <= w_enter && w_timed;
         r_value    <= w_enter ? w_dur : '0;
         r_lamps    <= lamps_of(w_next);
         r_walk     <= (w_next == ST_PED_WALK);
         r_ack      <= w_enter && (w_next == ST_PED_WALK);
      end
   end

   assign timer_load  = r_load;
   assign timer_value = r_value;
   assign {HG, HY, HR, FG, FY, FR} = r_lamps;
   assign ped_walk    = r_walk;
   assign ped_ack     = r_ack;

endmodule

`default_nettype wire

// File: tb/tb_tl_phase_scheduler.sv
// tb_tl_phase_scheduler: phase-level reference model with a scoreboard of timer loads
// and a per-cycle lamp check; TL_EMERGENCY_EN enables the emergency scenarios.
`timescale 1ns/1ps
`default_nettype none

module tb_tl_phase_scheduler;

   localparam int P_IDLE = 0, P_HG = 1, P_HY = 2, P_FG = 3, P_FY = 4, P_PED = 5, P_AR = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        c = 1'b0;
   logic        ped_req = 1'b0;
   logic        full;
   logic        timer_load;
   logic [11:0] timer_value;
   logic        HG, HY, HR, FG, FY, FR, ped_walk, ped_ack;
   logic        emg_in;
`ifdef TL_EMERGENCY_EN
   logic        emg_req = 1'b0;
   assign emg_in = emg_req;
`else
   assign emg_in = 1'b0;
`endif

   always #5 clk = ~clk;

   tl_phase_scheduler dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .c           (c),
      .ped_req     (ped_req),
      .full        (full),
      .timer_load  (timer_load),
      .timer_value (timer_value),
      .HG          (HG),
      .HY          (HY),
      .HR          (HR),
      .FG          (FG),
      .FY          (FY),
      .FR          (FR),
      .ped_walk    (ped_walk),
`ifdef TL_EMERGENCY_EN
      .emg_req     (emg_req),
`endif
      .ped_ack     (ped_ack)
   );

   // Timer model: loading N makes full pulse in the N-th cycle after the load cycle
   logic [11:0] tcnt = '0;
   always @(posedge clk) begin
      if (timer_load)    tcnt <= timer_value;
      else if (tcnt != 0) tcnt <= tcnt - 12'd1;
   end
   assign full = (tcnt == 12'd1);

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;

   typedef struct packed {
      logic [11:0] val;
      logic        ack;
      logic [6:0]  lamps;
   } exp_t;
   exp_t q[$];

   // {HG,HY,HR,FG,FY,FR,walk} for each phase, straight from the lamp table
   function automatic logic [6:0] lamps_of(input int p);
      case (p)
         P_HG:    return 7'b100_001_0;
         P_HY:    return 7'b010_001_0;
         P_FG:    return 7'b001_100_0;
         P_FY:    return 7'b001_010_0;
         P_PED:   return 7'b001_001_1;
         default: return 7'b001_001_0;
      endcase
   endfunction

   function automatic int dur_of(input int p);
      case (p)
         P_HG, P_FG: return 10;
         P_HY, P_FY: return 5;
         P_PED:      return 8;
         default:    return 0;
      endcase
   endfunction

   // Reference model: phase + cycles spent in it; a timed phase expires in cycle index == duration
   int m_phase = P_IDLE;
   int m_k = 0;
   bit m_fp = 0, m_pp = 0, m_rr = 0, m_emg = 0;

   always @(posedge clk) begin
      int  nx;
      bit  expd;
      if (reset) begin
         m_phase = P_IDLE; m_k = 0;
         m_fp = 0; m_pp = 0; m_rr = 0; m_emg = 0;
      end else begin
         expd = (m_phase == P_HG) ? (m_k >= 10) : (dur_of(m_phase) != 0 && m_k == dur_of(m_phase));
         if (m_phase inside {P_HG, P_HY, P_FG, P_FY}) m_emg = m_emg | emg_in;
         else m_emg = 0;
         nx = m_phase;
         case (m_phase)
            P_IDLE: if (start) nx = P_HG;
            P_HG:   if (emg_in || (expd && (m_fp || m_pp))) nx = P_HY;
            P_HY:   if (expd) begin
                       if (m_emg) nx = P_AR;
                       else begin
                          nx = (m_fp && (!m_pp || !m_rr)) ? P_FG : P_PED;
                          m_rr = !m_rr;
                       end
                    end
            P_FG:   if (expd || emg_in) nx = P_FY;
            P_FY:   if (expd) nx = m_emg ? P_AR : P_HG;
            P_PED:  if (emg_in) nx = P_AR; else if (expd) nx = P_HG;
            P_AR:   if (!emg_in) nx = P_HG;
            default: nx = P_IDLE;
         endcase
         if (nx == P_AR) m_emg = 0;
         m_fp = c       | (m_fp & !(nx == P_FG  && m_phase != P_FG));
         m_pp = ped_req | (m_pp & !(nx == P_PED && m_phase != P_PED));
         if (nx != m_phase) begin
            m_k = 0;
            if (dur_of(nx) != 0)
               q.push_back('{val: 12'(dur_of(nx)), ack: (nx == P_PED), lamps: lamps_of(nx)});
         end else begin
            m_k++;
         end
         m_phase = nx;
      end
   end

   // Monitor: lamps every cycle; each timer load pops one scoreboard entry
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         checks++;
         if ({HG, HY, HR, FG, FY, FR, ped_walk} !== lamps_of(m_phase)) begin
            errors++;
            $display("FAIL lamps t=%0t: got %b expected %b", $time,
                     {HG, HY, HR, FG, FY, FR, ped_walk}, lamps_of(m_phase));
         end
         checks++;
         if (timer_load) begin
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_load t=%0t: got load value %h expected no load", $time, timer_value);
            end else begin
               e = q.pop_front();
               if (timer_value !== e.val || ped_ack !== e.ack) begin
                  errors++;
                  $display("FAIL load t=%0t: got value %h ack %b expected value %h ack %b",
                           $time, timer_value, ped_ack, e.val, e.ack);
               end
            end
         end else if (ped_ack !== 1'b0 || q.size() > 1) begin
            errors++;
            $display("FAIL no_load t=%0t: got ack %b pending %0d expected ack 0 pending <=1",
                     $time, ped_ack, q.size());
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      run(2);
      chk("rst_lamps", {25'd0, HG, HY, HR, FG, FY, FR, ped_walk}, 32'b001_001_0);
      chk("rst_load", {31'd0, timer_load}, 32'd0);
      chk("rst_value", {20'd0, timer_value}, 32'd0);
      chk("rst_ack", {31'd0, ped_ack}, 32'd0);
      mon_en = 1;
      reset = 0;
      start = 1;
      cyc();
      chk("start_load", {20'd0, timer_value}, 32'h00A);
      run(40);
      chk("hwy_hold", {31'd0, HG}, 32'd1);

      c = 1; cyc(); c = 0;
      run(60);

      ped_req = 1; cyc(); ped_req = 0;
      run(40);

      c = 1; ped_req = 1;
      run(120);
      c = 0; ped_req = 0;
      run(40);

      // Reset while farm green is counting
      c = 1;
      for (int i = 0; i < 200 && !FG; i++) cyc();
      chk("wait_farm_g", {31'd0, FG}, 32'd1);
      c = 0;
      run(3);
      start = 0; reset = 1;
      cyc();
      chk("midreset_lamps", {26'd0, HG, HY, HR, FG, FY, FR}, 32'b001_001);
      chk("midreset_load", {31'd0, timer_load}, 32'd0);
      reset = 0;
      run(25);
      chk("idle_hold", {31'd0, HG}, 32'd0);
      start = 1;
      run(30);

`ifdef TL_EMERGENCY_EN
      for (int i = 0; i < 200 && !HG; i++) cyc();
      chk("wait_hwy_g", {31'd0, HG}, 32'd1);
      emg_req = 1;
      run(30);
      chk("all_red", {26'd0, HG, HY, HR, FG, FY, FR}, 32'b001_001);
      emg_req = 0;
      run(20);
`endif

      for (int i = 0; i < 1500; i++) begin
         cyc();
         if ($urandom_range(0, 15) == 0) c = ~c;
         ped_req = ($urandom_range(0, 29) == 0);
         reset   = ($urandom_range(0, 399) == 0);
`ifdef TL_EMERGENCY_EN
         if ($urandom_range(0, 59) == 0) emg_req = ~emg_req;
`endif
      end
      c = 0; ped_req = 0; reset = 0;
`ifdef TL_EMERGENCY_EN
      emg_req = 0;
`endif
      run(40);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
